mole_sequencer: RTL

- Game-control stage directly downstream of the clock divider in the whack-a-mole design.
- Consumes the divider's slow_clk as a game tick. Pseudo-randomly raises one mole at a time and judges player button presses.
- Keeps score and the game countdown; drives the mole LEDs and the score/time display path.
- All logic runs on the fast clk. slow_clk is sampled as data only, never used as a clock.

---
 rtl/mole_sequencer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/mole_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : mole_sequencer
// Purpose  : Whack-a-mole game control. Ticks on slow_clk edges, raises one
//            LFSR-chosen mole at a time, judges presses, and keeps score and
//            countdown. Build macro WRONG_PRESS_PENALTY_EN enables a score
//            penalty for presses on non-raised moles.
// Revision : 1.0 - initial release
// =============================================================================
module mole_sequencer #(
    parameter int          NUM_MOLES  = 4,
    parameter int          UP_TICKS   = 3,
    parameter int          GAP_TICKS  = 1,
    parameter int          GAME_TICKS = 60,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 slow_clk,
    input  logic                 start,
    input  logic [NUM_MOLES-1:0] btn,
    output logic [NUM_MOLES-1:0] mole,
    output logic [7:0]           score,
    output logic [7:0]           time_left,
    output logic                 game_over,
    output logic                 hit_pulse,
    output logic                 miss_pulse
);

    localparam int                   C_IDX_W     = $clog2(NUM_MOLES);
    localparam int                   C_UP_W      = $clog2(UP_TICKS + 1);
    localparam int                   C_GAP_W     = $clog2(GAP_TICKS + 1);
    localparam logic [C_UP_W-1:0]    C_UP_INIT   = C_UP_W'(UP_TICKS);
    localparam logic [C_GAP_W-1:0]   C_GAP_INIT  = C_GAP_W'(GAP_TICKS);
    localparam logic [7:0]           C_GAME_INIT = 8'(GAME_TICKS);
    localparam logic [7:0]           C_NUM_MOLES = 8'(NUM_MOLES);
    localparam logic [C_IDX_W-1:0]   C_IDX_LAST  = C_IDX_W'(NUM_MOLES - 1);
    localparam logic [NUM_MOLES-1:0] C_ONE       = NUM_MOLES'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_UP    = 3'd2,
        S_GAP   = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_sync1, r_sync2, r_sync3, r_tick;
    logic [NUM_MOLES-1:0] r_btn_q;
    logic [15:0]          r_lfsr;
    logic [C_IDX_W-1:0]   r_idx, w_idx_nxt;
    logic                 r_prev_vld, w_prev_vld_nxt;
    logic [C_UP_W-1:0]    r_up_cnt, w_up_nxt;
    logic [C_GAP_W-1:0]   r_gap_cnt, w_gap_nxt;
    logic [NUM_MOLES-1:0] r_mole, w_mole_nxt;
    logic [7:0]           r_score, w_score_nxt;
    logic [7:0]           r_time, w_time_nxt;
    logic                 r_game_over, w_over_nxt;
    logic                 r_hit, w_hit_nxt;
    logic                 r_miss, w_miss_nxt;

    logic                 w_lfsr_fb;
    logic [NUM_MOLES-1:0] w_press;
    logic [C_IDX_W-1:0]   w_idx_raw, w_idx;
    logic                 w_hit, w_in_game;

    // slow_clk is data only: two sync flops, then a registered rising-edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_tick  <= 1'b0;
            r_btn_q <= '0;
            r_lfsr  <= LFSR_SEED;
        end else begin
            r_sync1 <= slow_clk;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_tick  <= r_sync2 & ~r_sync3;
            r_btn_q <= btn;
            r_lfsr  <= {w_lfsr_fb, r_lfsr[15:1]};
        end
    end

    assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_press   = btn & ~r_btn_q;
    assign w_hit     = |(w_press & r_mole);
    assign w_in_game = (r_state == S_SPAWN) || (r_state == S_UP) || (r_state == S_GAP);

    // Never repeat the previous mole: bump to the next position on a collision
    assign w_idx_raw = C_IDX_W'(r_lfsr[7:0] % C_NUM_MOLES);
    assign w_idx     = (r_prev_vld && (w_idx_raw == r_idx)) ?
                       ((w_idx_raw == C_IDX_LAST) ? '0 : w_idx_raw + C_IDX_W'(1)) :
                       w_idx_raw;

`ifdef WRONG_PRESS_PENALTY_EN
    logic w_wrong;
    assign w_wrong = |(w_press & ~r_mole);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_prev_vld  <= 1'b0;
            r_up_cnt    <= '0;
            r_gap_cnt   <= '0;
            r_mole      <= '0;
            r_score     <= '0;
            r_time      <= '0;
            r_game_over <= 1'b0;
            r_hit       <= 1'b0;
            r_miss      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_prev_vld  <= w_prev_vld_nxt;
            r_up_cnt    <= w_up_nxt;
            r_gap_cnt   <= w_gap_nxt;
            r_mole      <= w_mole_nxt;
            r_score     <= w_score_nxt;
            r_time      <= w_time_nxt;
            r_game_over <= w_over_nxt;
            r_hit       <= w_hit_nxt;
            r_miss      <= w_miss_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_prev_vld_nxt = r_prev_vld;
        w_up_nxt       = r_up_cnt;
        w_gap_nxt      = r_gap_cnt;
        w_mole_nxt     = r_mole;
        w_score_nxt    = r_score;
        w_time_nxt     = r_time;
        w_over_nxt     = r_game_over;
        w_hit_nxt      = 1'b0;
        w_miss_nxt     = 1'b0;

        case (r_state)
            S_IDLE, S_OVER: begin
                w_mole_nxt = '0;
                if (start) begin
                    w_score_nxt = '0;
                    w_time_nxt  = C_GAME_INIT;
                    w_over_nxt  = 1'b0;
                    w_state_nxt = S_SPAWN;
                end
            end
            S_SPAWN: begin
                w_mole_nxt     = C_ONE << w_idx;
                w_idx_nxt      = w_idx;
                w_prev_vld_nxt = 1'b1;
                w_up_nxt       = C_UP_INIT;
                w_state_nxt    = S_UP;
            end
            S_UP: begin
                if (w_hit) begin
                    if (r_score != 8'hFF) begin
                        w_score_nxt = r_score + 8'd1;
                    end
                    w_hit_nxt   = 1'b1;
                    w_mole_nxt  = '0;
                    w_gap_nxt   = C_GAP_INIT;
                    w_state_nxt = S_GAP;
                end else begin
                    if (r_tick) begin
                        if (r_up_cnt == C_UP_W'(1)) begin
                            w_miss_nxt  = 1'b1;
                            w_mole_nxt  = '0;
                            w_gap_nxt   = C_GAP_INIT;
                            w_state_nxt = S_GAP;
                        end else begin
                            w_up_nxt = r_up_cnt - C_UP_W'(1);
                        end
                    end
`ifdef WRONG_PRESS_PENALTY_EN
                    if (w_wrong) begin
                        if (r_score != 8'd0) begin
                            w_score_nxt = r_score - 8'd1;
                        end
                        w_miss_nxt = 1'b1;
                    end
`endif
                end
            end
            S_GAP: begin
                if (r_tick) begin
                    if (r_gap_cnt == C_GAP_W'(1)) begin
                        w_state_nxt = S_SPAWN;
                    end else begin
                        w_gap_nxt = r_gap_cnt - C_GAP_W'(1);
                    end
                end
            end
            default: begin
                w_mole_nxt  = '0;
                w_state_nxt = S_IDLE;
            end
        endcase

        // Countdown expiry overrides every other transition; a same-cycle hit still counts
        if (w_in_game && r_tick) begin
            w_time_nxt = r_time - 8'd1;
            if (r_time == 8'd1) begin
                w_state_nxt = S_OVER;
                w_mole_nxt  = '0;
                w_over_nxt  = 1'b1;
                w_miss_nxt  = 1'b0;
            end
        end
    end

    assign mole       = r_mole;
    assign score      = r_score;
    assign time_left  = r_time;
    assign game_over  = r_game_over;
    assign hit_pulse  = r_hit;
    assign miss_pulse = r_miss;

endmodule
`default_nettype wire
